imm_gen_pipe: RTL and testbench

- Pipelined, parametrised immediate generator for the decode stage.
- Takes instruction bits [31:7] plus an immediate-type select and produces an XLEN-wide extended immediate, registered, with a forwarded tag (e.g. rd/ROB index).
- Uses a valid/ready handshake on both sides through a 2-entry skid buffer, so decode can stall without dropping or duplicating immediates.
- Supports RV32/RV64 and adds CSR zimm and shift-amount formats.

---
 rtl/imm_gen_pipe.sv | 150 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator for the decode stage.
// Extends instruction bits [31:7] into an XLEN-wide immediate according to
// in_imm_src, captures it with a sideband tag, and hands it downstream through
// a 2-entry skid buffer (main register M, skid register K) so that in_ready
// never depends combinationally on out_ready.
// Optional feature macro: IMM_GEN_PIPE_ERR_EN adds the out_err port, which flags
// illegal formats (111, or 110 with instr[25]=1 when XLEN=32).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_imm_src,
  input  logic [24:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_PIPE_ERR_EN
  ,
  output logic             out_err
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Port bit n of in_instr carries instr[n+7], so instr[31] is ins[24].
  function automatic logic [XLEN-1:0] ext_imm(input logic [2:0] src, input logic [24:0] ins);
    logic [XLEN-1:0] r;
    case (src)
      3'b000: r = XLEN'($signed(ins[24:13]));
      3'b001: r = XLEN'($signed({ins[24:18], ins[4:0]}));
      3'b010: r = XLEN'($signed({ins[24], ins[0], ins[23:18], ins[4:1], 1'b0}));
      3'b011: r = XLEN'($signed({ins[24:5], 12'h000}));
      3'b100: r = XLEN'($signed({ins[24], ins[12:5], ins[13], ins[23:14], 1'b0}));
      3'b101: r = XLEN'(ins[12:8]);
      3'b110: begin
        if (XLEN == 64) begin
          r = XLEN'(ins[18:13]);
`ifdef IMM_GEN_PIPE_ERR_EN
        end else if (ins[18]) begin
          // shamt >= 32 is not encodable on RV32: flagged, immediate forced to zero
          r = {XLEN{1'b0}};
`endif
        end else begin
          r = XLEN'(ins[17:13]);
        end
      end
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

`ifdef IMM_GEN_PIPE_ERR_EN
  function automatic logic is_illegal(input logic [2:0] src, input logic [24:0] ins);
    return (src == 3'b111) || ((src == 3'b110) && (XLEN == 32) && ins[18]);
  endfunction
`endif

  logic [1:0]       state;
  logic [XLEN-1:0]  m_imm;
  logic [TAG_W-1:0] m_tag;
  logic [XLEN-1:0]  k_imm;
  logic [TAG_W-1:0] k_tag;
  logic [XLEN-1:0]  new_imm;
  logic             accept;
  logic             fire;
`ifdef IMM_GEN_PIPE_ERR_EN
  logic             m_err;
  logic             k_err;
  logic             new_err;

  assign new_err = is_illegal(in_imm_src, in_instr);
  assign out_err = m_err;
`endif

  assign new_imm   = ext_imm(in_imm_src, in_instr);
  // rst_n gates in_ready so nothing is accepted while reset is held.
  assign in_ready  = (state != ST_TWO) & rst_n;
  assign out_valid = (state != ST_EMPTY);
  assign out_imm   = m_imm;
  assign out_tag   = m_tag;
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  // Skid FSM and M/K capture; the async reset drops any held entries at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      m_imm <= {XLEN{1'b0}};
      m_tag <= {TAG_W{1'b0}};
      k_imm <= {XLEN{1'b0}};
      k_tag <= {TAG_W{1'b0}};
`ifdef IMM_GEN_PIPE_ERR_EN
      m_err <= 1'b0;
      k_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            m_imm <= new_imm;
            m_tag <= in_tag;
`ifdef IMM_GEN_PIPE_ERR_EN
            m_err <= new_err;
`endif
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && fire) begin
            m_imm <= new_imm;
            m_tag <= in_tag;
`ifdef IMM_GEN_PIPE_ERR_EN
            m_err <= new_err;
`endif
          end else if (accept) begin
            // M is still waiting on downstream: park the newcomer in K
            k_imm <= new_imm;
            k_tag <= in_tag;
`ifdef IMM_GEN_PIPE_ERR_EN
            k_err <= new_err;
`endif
            state <= ST_TWO;
          end else if (fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (fire) begin
            m_imm <= k_imm;
            m_tag <= k_tag;
`ifdef IMM_GEN_PIPE_ERR_EN
            m_err <= k_err;
`endif
            state <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance
// share clock and reset. Expected entries are queued when stimulus is accepted
// and compared in order when the DUT fires an output.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v32, r32, ov32, or32;
  logic [2:0]  s32;
  logic [24:0] i32;
  logic [4:0]  t32, ot32;
  logic [31:0] oi32;
  logic        v64, r64, ov64, or64;
  logic [2:0]  s64;
  logic [24:0] i64;
  logic [4:0]  t64, ot64;
  logic [63:0] oi64;
`ifdef IMM_GEN_PIPE_ERR_EN
  logic        oe32, oe64;
`endif

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .in_imm_src(s32),
    .in_instr(i32), .in_tag(t32), .out_valid(ov32), .out_ready(or32),
    .out_imm(oi32), .out_tag(ot32)
`ifdef IMM_GEN_PIPE_ERR_EN
    , .out_err(oe32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64), .in_imm_src(s64),
    .in_instr(i64), .in_tag(t64), .out_valid(ov64), .out_ready(or64),
    .out_imm(oi64), .out_tag(ot64)
`ifdef IMM_GEN_PIPE_ERR_EN
    , .out_err(oe64)
`endif
  );

  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  int   tests = 0;
  int   fails = 0;
  bit   rnd_on;

  // Reference immediate built from the full 32-bit instruction word.
  function automatic logic [63:0] model(input int xlen, input logic [2:0] src, input logic [31:0] i);
    logic [63:0] r;
    case (src)
      3'd0: r = {{52{i[31]}}, i[31:20]};
      3'd1: r = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd2: r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: r = {{32{i[31]}}, i[31:12], 12'h000};
      3'd4: r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd5: r = {59'd0, i[19:15]};
      3'd6: begin
        if (xlen == 64) r = {58'd0, i[25:20]};
`ifdef IMM_GEN_PIPE_ERR_EN
        else if (i[25]) r = 64'd0;
`endif
        else r = {59'd0, i[24:20]};
      end
      default: r = 64'd0;
    endcase
    if (xlen == 32) r = {32'd0, r[31:0]};
    return r;
  endfunction

  function automatic logic model_err(input int xlen, input logic [2:0] src, input logic [31:0] i);
`ifdef IMM_GEN_PIPE_ERR_EN
    return (src == 3'd7) || ((src == 3'd6) && (xlen == 32) && i[25]);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one entry (waiting a bounded time for in_ready) and queue its expectation.
  task automatic send(input bit d64, input logic [2:0] src, input logic [31:0] ins,
                      input logic [4:0] tag, input logic [63:0] eimm);
    int   n;
    exp_t x;
    n = 0;
    while (((d64 ? r64 : r32) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    x.imm = eimm;
    x.tag = tag;
    x.err = model_err(d64 ? 64 : 32, src, ins);
    if ((d64 ? r64 : r32) !== 1'b1) begin
      tests++; fails++;
      $display("FAIL send_ready_timeout dut64=%0d tag=%0d in_ready never rose", d64, tag);
    end else if (d64) begin
      v64 = 1'b1; s64 = src; i64 = ins[31:7]; t64 = tag;
      q64.push_back(x);
      @(negedge clk);
      v64 = 1'b0;
    end else begin
      v32 = 1'b1; s32 = src; i32 = ins[31:7]; t32 = tag;
      q32.push_back(x);
      @(negedge clk);
      v32 = 1'b0;
    end
  endtask

  // Scoreboard: compare every fired output against the oldest queued expectation.
  always begin
    @(negedge clk);
    #3;
    if (rst_n && ov32 && or32) begin
      tests++;
      if (q32.size() == 0) begin
        fails++;
        $display("FAIL sb32_unexpected tag=%0d imm=%h required=no output", ot32, oi32);
      end else begin
        e32 = q32.pop_front();
        if (oi32 !== e32.imm[31:0] || ot32 !== e32.tag
`ifdef IMM_GEN_PIPE_ERR_EN
            || oe32 !== e32.err
`endif
           ) begin
          fails++;
          $display("FAIL sb32 imm=%h tag=%0d actual, required imm=%h tag=%0d err=%0b",
                   oi32, ot32, e32.imm[31:0], e32.tag, e32.err);
        end
      end
    end
    if (rst_n && ov64 && or64) begin
      tests++;
      if (q64.size() == 0) begin
        fails++;
        $display("FAIL sb64_unexpected tag=%0d imm=%h required=no output", ot64, oi64);
      end else begin
        e64 = q64.pop_front();
        if (oi64 !== e64.imm || ot64 !== e64.tag
`ifdef IMM_GEN_PIPE_ERR_EN
            || oe64 !== e64.err
`endif
           ) begin
          fails++;
          $display("FAIL sb64 imm=%h tag=%0d actual, required imm=%h tag=%0d err=%0b",
                   oi64, ot64, e64.imm, e64.tag, e64.err);
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q32.size() != 0 || q64.size() != 0) begin
      fails++;
      $display("FAIL drain pending32=%0d pending64=%0d required 0", q32.size(), q64.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v32 = 1'b0; s32 = 3'd0; i32 = 25'd0; t32 = 5'd0; or32 = 1'b0;
    v64 = 1'b0; s64 = 3'd0; i64 = 25'd0; t64 = 5'd0; or64 = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (ov32 !== 1'b0 || r32 !== 1'b0 || oi32 !== 32'd0 || ot32 !== 5'd0) begin
      fails++;
      $display("FAIL reset32 valid=%b ready=%b imm=%h tag=%0d required all 0", ov32, r32, oi32, ot32);
    end
    tests++;
    if (ov64 !== 1'b0 || r64 !== 1'b0 || oi64 !== 64'd0 || ot64 !== 5'd0) begin
      fails++;
      $display("FAIL reset64 valid=%b ready=%b imm=%h tag=%0d required all 0", ov64, r64, oi64, ot64);
    end
  endtask

  task automatic test_first_accept();
    rst_n = 1'b1;
    or32 = 1'b1;
    or64 = 1'b1;
    #1;
    tests++;
    if (r32 !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset actual=%b required=1", r32);
    end
    send(1'b0, 3'd0, 32'hFFF00093, 5'd3, 64'hFFFFFFFF);
    tests++;
    if (ov32 !== 1'b1 || oi32 !== 32'hFFFFFFFF || ot32 !== 5'd3) begin
      fails++;
      $display("FAIL first_accept valid=%b imm=%h tag=%0d required 1 ffffffff 3", ov32, oi32, ot32);
    end
  endtask

  task automatic test_back_to_back();
    send(1'b0, 3'd2, 32'hFE000EE3, 5'd4, 64'hFFFFFFFC);
    tests++;
    if (ov32 !== 1'b1 || ot32 !== 5'd4 || oi32 !== 32'hFFFFFFFC) begin
      fails++;
      $display("FAIL b2b_first valid=%b tag=%0d imm=%h required 1 4 fffffffc", ov32, ot32, oi32);
    end
    send(1'b0, 3'd4, 32'h0010006F, 5'd5, 64'h00000800);
    tests++;
    if (ov32 !== 1'b1 || ot32 !== 5'd5 || oi32 !== 32'h00000800) begin
      fails++;
      $display("FAIL b2b_second valid=%b tag=%0d imm=%h required 1 5 00000800", ov32, ot32, oi32);
    end
    drain();
    tests++;
    if (ov32 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_empty valid=%b required 0", ov32);
    end
  endtask

  task automatic test_xlen64();
    send(1'b1, 3'd3, 32'h800002B7, 5'd9, 64'hFFFFFFFF80000000);
    tests++;
    if (oi64 !== 64'hFFFFFFFF80000000) begin
      fails++;
      $display("FAIL u64 imm=%h required ffffffff80000000", oi64);
    end
    send(1'b1, 3'd5, 32'h000F8073, 5'd10, 64'h1F);
    send(1'b1, 3'd6, 32'h03F00013, 5'd11, 64'h3F);
    drain();
  endtask

  task automatic test_backpressure();
    or32 = 1'b0;
    send(1'b0, 3'd0, 32'h00100093, 5'd1, 64'h1);
    send(1'b0, 3'd0, 32'h80000013, 5'd2, 64'hFFFFF800);
    tests++;
    if (r32 !== 1'b0 || ot32 !== 5'd1 || ov32 !== 1'b1) begin
      fails++;
      $display("FAIL bp_full ready=%b tag=%0d valid=%b required 0 1 1", r32, ot32, ov32);
    end
    @(negedge clk);
    tests++;
    if (ot32 !== 5'd1 || oi32 !== 32'h1) begin
      fails++;
      $display("FAIL bp_hold tag=%0d imm=%h required 1 00000001", ot32, oi32);
    end
    or32 = 1'b1;
    @(negedge clk);
    tests++;
    if (ot32 !== 5'd2 || r32 !== 1'b1 || ov32 !== 1'b1) begin
      fails++;
      $display("FAIL bp_release tag=%0d ready=%b valid=%b required 2 1 1", ot32, r32, ov32);
    end
    @(negedge clk);
    tests++;
    if (ov32 !== 1'b0) begin
      fails++;
      $display("FAIL bp_empty valid=%b required 0", ov32);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    or32 = 1'b0;
    or64 = 1'b0;
    send(1'b1, 3'd0, 32'h00700093, 5'd20, 64'h7);
    send(1'b0, 3'd0, 32'h00100093, 5'd12, 64'h1);
    send(1'b0, 3'd0, 32'h00200093, 5'd13, 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (ov32 !== 1'b0 || r32 !== 1'b0 || ot32 !== 5'd0 || oi32 !== 32'd0 || ov64 !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid valid=%b ready=%b tag=%0d imm=%h valid64=%b required all 0",
               ov32, r32, ot32, oi32, ov64);
    end
    q32.delete();
    q64.delete();
    @(negedge clk);
    rst_n = 1'b1;
    or32 = 1'b1;
    or64 = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0) begin
      fails++;
      $display("FAIL stale_after_reset valid32=%b valid64=%b required 0 0", ov32, ov64);
    end
  endtask

`ifdef IMM_GEN_PIPE_ERR_EN
  task automatic test_err();
    or32 = 1'b1;
    or64 = 1'b1;
    send(1'b0, 3'd7, 32'hFFFFFFFF, 5'd14, 64'h0);
    tests++;
    if (oe32 !== 1'b1 || oi32 !== 32'd0) begin
      fails++;
      $display("FAIL err_111 err=%b imm=%h required 1 00000000", oe32, oi32);
    end
    send(1'b0, 3'd6, 32'h02000013, 5'd15, 64'h0);
    tests++;
    if (oe32 !== 1'b1 || oi32 !== 32'd0) begin
      fails++;
      $display("FAIL err_shamt32 err=%b imm=%h required 1 00000000", oe32, oi32);
    end
    send(1'b0, 3'd0, 32'h00500013, 5'd16, 64'h5);
    tests++;
    if (oe32 !== 1'b0 || oi32 !== 32'h5) begin
      fails++;
      $display("FAIL err_clear err=%b imm=%h required 0 00000005", oe32, oi32);
    end
    send(1'b1, 3'd6, 32'h03F00013, 5'd17, 64'h3F);
    tests++;
    if (oe64 !== 1'b0 || oi64 !== 64'h3F) begin
      fails++;
      $display("FAIL err_shamt64 err=%b imm=%h required 0 3f", oe64, oi64);
    end
    drain();
  endtask
`endif

  task automatic test_random();
    logic [31:0] ins;
    logic [2:0]  src;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(negedge clk);
          or32 = 1'($urandom_range(0, 1));
          or64 = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int k = 0; k < 24; k++) begin
          ins = $urandom();
          src = 3'($urandom_range(0, 7));
`ifndef IMM_GEN_PIPE_ERR_EN
          if (src == 3'd6) ins[25] = 1'b0;
`endif
          send(1'b0, src, ins, 5'(k), model(32, src, ins));
          ins = $urandom();
          src = 3'($urandom_range(0, 7));
          send(1'b1, src, ins, 5'(k + 8), model(64, src, ins));
        end
        rnd_on = 1'b0;
      end
    join
    or32 = 1'b1;
    or64 = 1'b1;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_accept();
    test_back_to_back();
    test_xlen64();
    test_backpressure();
`ifdef IMM_GEN_PIPE_ERR_EN
    test_err();
`endif
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
